// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if
//   Bundles the register-block side of the UART transmit path.
//   master (register block) drives:
//     lcr[7:0]     line control: word length, stop bits, parity, break
//     tf_push      write wb_dat_i into the transmit FIFO
//     wb_dat_i     byte to transmit
//     tx_reset     one-clk synchronous FIFO flush
//   slave (transmitter) drives:
//     tf_count     current FIFO occupancy
//     tf_overrun   sticky, a push was attempted while the FIFO was full
//     thre         FIFO empty
//     temt         FIFO empty and shifter idle
interface uart_transmitter_if #(
  parameter int FIFO_CNT_W = 5
);
  logic [7:0]            lcr;
  logic                  tf_push;
  logic [7:0]            wb_dat_i;
  logic                  tx_reset;
  logic [FIFO_CNT_W-1:0] tf_count;
  logic                  tf_overrun;
  logic                  thre;
  logic                  temt;

  modport master (
    output lcr, tf_push, wb_dat_i, tx_reset,
    input  tf_count, tf_overrun, thre, temt
  );

  modport slave (
    input  lcr, tf_push, wb_dat_i, tx_reset,
    output tf_count, tf_overrun, thre, temt
  );
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Transmit FIFO plus serialiser. Each byte goes out as a start bit,
//   5-8 data bits LSB first, optional parity and 1 / 1.5 / 2 stop bits.
//   Every bit lasts 16 ticks of the shared 16x baud enable.
// Ports:
//   clk        system clock
//   wb_rst_n   asynchronous active-low reset
//   enable     16x baud tick, one clk wide
//   stx_pad_o  registered serial output, idle high
//   bus        register-block interface (slave modport)
module uart_transmitter #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_CNT_W = 5
) (
  input  logic               clk,
  input  logic               wb_rst_n,
  input  logic               enable,
  output logic               stx_pad_o,
  uart_transmitter_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_n;
  logic [3:0]            tick, tick_n;
  logic [2:0]            bit_cnt, bit_cnt_n;
  logic [7:0]            shift, shift_n;
  logic                  par, par_n;
  logic [1:0]            wlen, wlen_n;
  logic                  pe, pe_n;
  logic                  stop2, stop2_n;
  logic                  line_n;
  logic                  pop;

  logic [7:0]            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [FIFO_CNT_W-1:0] count;
  logic                  overrun;
  logic                  full;
  logic                  push_ok;
  logic [7:0]            head;
  logic [7:0]            word_mask;
  logic                  new_par;
  logic                  unused_lcr;

  assign unused_lcr = bus.lcr[7];
  assign head       = fifo_mem[rd_ptr];
  assign full       = (count == FIFO_CNT_W'(FIFO_DEPTH));
  // A full FIFO still accepts a push when the shifter pops in the same clk.
  assign push_ok    = bus.tf_push && (!full || pop);

  // Parity only covers the bits of the configured word length.
  always_comb begin
    case (bus.lcr[1:0])
      2'b00:   word_mask = 8'h1F;
      2'b01:   word_mask = 8'h3F;
      2'b10:   word_mask = 8'h7F;
      default: word_mask = 8'hFF;
    endcase
  end

  assign new_par = bus.lcr[5] ? ~bus.lcr[4]
                 : (bus.lcr[4] ? ^(head & word_mask) : ~^(head & word_mask));

  // FIFO bookkeeping; tx_reset wins over a coincident push.
  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else if (bus.tx_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + FIFO_CNT_W'(1);
        2'b01:   count <= count - FIFO_CNT_W'(1);
        default: count <= count;
      endcase
      if (bus.tf_push && !push_ok) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !bus.tx_reset) fifo_mem[wr_ptr] <= bus.wb_dat_i;
  end

  // Frame state register. Break is applied on the output register only,
  // so the state machine keeps running underneath it.
  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state     <= IDLE;
      tick      <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      par       <= 1'b0;
      wlen      <= '0;
      pe        <= 1'b0;
      stop2     <= 1'b0;
      stx_pad_o <= 1'b1;
    end else begin
      state     <= state_n;
      tick      <= tick_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      par       <= par_n;
      wlen      <= wlen_n;
      pe        <= pe_n;
      stop2     <= stop2_n;
      stx_pad_o <= bus.lcr[6] ? 1'b0 : line_n;
    end
  end

  // Next-state logic. Frame settings are captured at pop so lcr changes
  // mid-frame only affect the next frame. In STOP the bit counter is reused
  // to mark a pending second (or half) stop period.
  always_comb begin
    state_n   = state;
    tick_n    = tick;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    wlen_n    = wlen;
    pe_n      = pe;
    stop2_n   = stop2;
    pop       = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            pop       = 1'b1;
            shift_n   = head;
            wlen_n    = bus.lcr[1:0];
            pe_n      = bus.lcr[3];
            stop2_n   = bus.lcr[2];
            bit_cnt_n = 3'd4 + {1'b0, bus.lcr[1:0]};
            par_n     = new_par;
            tick_n    = 4'd15;
            state_n   = START;
          end
        end
        START: begin
          if (tick == 4'd0) begin
            tick_n  = 4'd15;
            state_n = DATA;
          end else begin
            tick_n = tick - 4'd1;
          end
        end
        DATA: begin
          if (tick == 4'd0) begin
            tick_n  = 4'd15;
            shift_n = {1'b0, shift[7:1]};
            if (bit_cnt == 3'd0) begin
              if (pe) begin
                state_n = PARITY;
              end else begin
                state_n   = STOP;
                bit_cnt_n = {2'b00, stop2};
              end
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
            end
          end else begin
            tick_n = tick - 4'd1;
          end
        end
        PARITY: begin
          if (tick == 4'd0) begin
            tick_n    = 4'd15;
            bit_cnt_n = {2'b00, stop2};
            state_n   = STOP;
          end else begin
            tick_n = tick - 4'd1;
          end
        end
        STOP: begin
          if (tick == 4'd0) begin
            if (bit_cnt != 3'd0) begin
              // 5-bit words get 1.5 stop bits, longer words get 2.
              bit_cnt_n = 3'd0;
              tick_n    = (wlen == 2'b00) ? 4'd7 : 4'd15;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tick_n = tick - 4'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Line level that belongs to the state being entered.
  always_comb begin
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shift_n[0];
      PARITY:  line_n = par_n;
      default: line_n = 1'b1;
    endcase
  end

  assign bus.tf_count   = count;
  assign bus.tf_overrun = overrun;
  assign bus.thre       = (count == '0);
  assign bus.temt       = (count == '0) && (state == IDLE);

endmodule
